// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: operand width, op codes and
// the sequencer state encoding.
package alu_pkg;

  localparam int W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared 4-bit combinational ALU. Carry is the adder carry for add, the borrow
// for sub, and the bit shifted out for the shifts; logic ops clear it.
module ALU
  import alu_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op_code,
  output logic [W-1:0] result,
  output logic         carry_out
);

  logic [W:0] w_wide;

  always_comb begin
    w_wide    = '0;
    result    = '0;
    carry_out = 1'b0;
    case (op_code)
      OP_ADD: begin
        w_wide    = {1'b0, a} + {1'b0, b};
        result    = w_wide[W-1:0];
        carry_out = w_wide[W];
      end
      OP_SUB: begin
        w_wide    = {1'b0, a} - {1'b0, b};
        result    = w_wide[W-1:0];
        carry_out = w_wide[W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result    = {a[W-2:0], 1'b0};
        carry_out = a[W-1];
      end
      OP_SHR: begin
        result    = {1'b0, a[W-1:1]};
        carry_out = a[0];
      end
      default: begin
        result    = '0;
        carry_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared ALU: accept a request,
// execute it from latched operands, and hold the response until taken.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  logic [W-1:0]     req_a0,
  input  logic [W-1:0]     req_b0,
  input  logic [W-1:0]     req_a1,
  input  logic [W-1:0]     req_b1,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  output logic [N_REQ-1:0] resp_valid,
  input  logic [N_REQ-1:0] resp_ready,
  output logic [W-1:0]     resp_result,
  output logic             resp_carry,
  output logic             busy,
  output logic [7:0]       ops_done
);

  state_t             r_state;
  logic               r_lastGrant;
  logic               r_id;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [2:0]         r_op;
  logic [W-1:0]       r_result;
  logic               r_carry;
  logic [N_REQ-1:0]   r_respValid;
  logic               r_busy;
  logic [7:0]         r_opsDone;

  logic               w_grantId;
  logic [N_REQ-1:0]   w_reqReady;
  logic               w_accept;
  logic [W-1:0]       w_selA;
  logic [W-1:0]       w_selB;
  logic [2:0]         w_selOp;
  logic [W-1:0]       w_aluResult;
  logic               w_aluCarry;

  // Under contention the requester that was not served last wins.
  always_comb begin
    w_grantId = 1'b0;
    case (req_valid)
      2'b10:   w_grantId = 1'b1;
      2'b11:   w_grantId = ~r_lastGrant;
      default: w_grantId = 1'b0;
    endcase
  end

  always_comb begin
    w_reqReady = '0;
    if (r_state == IDLE && req_valid != '0)
      w_reqReady = N_REQ'(1) << w_grantId;
  end

  assign w_accept = (w_reqReady & req_valid) != '0;

  assign w_selA  = w_grantId ? req_a1  : req_a0;
  assign w_selB  = w_grantId ? req_b1  : req_b0;
  assign w_selOp = w_grantId ? req_op1 : req_op0;

  ALU u_alu (
    .a         (r_a),
    .b         (r_b),
    .op_code   (r_op),
    .result    (w_aluResult),
    .carry_out (w_aluCarry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lastGrant <= 1'b1;
      r_id        <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_respValid <= '0;
      r_busy      <= 1'b0;
      r_opsDone   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= w_selA;
            r_b     <= w_selB;
            r_op    <= w_selOp;
            r_id    <= w_grantId;
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_result    <= w_aluResult;
          r_carry     <= w_aluCarry;
          r_respValid <= N_REQ'(1) << r_id;
          r_state     <= RESP;
        end
        RESP: begin
          // Only the addressed requester's accept can retire the response.
          if (resp_ready[r_id]) begin
            r_respValid <= '0;
            r_opsDone   <= r_opsDone + 8'd1;
            r_lastGrant <= r_id;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_respValid <= '0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = w_reqReady;
  assign resp_valid  = r_respValid;
  assign resp_result = r_result;
  assign resp_carry  = r_carry;
  assign busy        = r_busy;
  assign ops_done    = r_opsDone;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 4-bit combinational ALU. It accepts operation requests (operands plus 3-bit op code) from two independent clients over valid/ready handshakes, and latches the winning request into operand registers. It drives the ALU from those registers, registers the result and carry, and returns them to the originating client over a held response handshake. It sits between the client blocks and the single ALU instance, so neither client ever drives the ALU directly.

## Interface
- `N_REQ`, default 2: number of requesters; fixed at 2 for this revision.
- `W`, default 4: operand and result width; matches the ALU.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input [1:0]: per-requester request valid.
- `req_ready` output [1:0]: per-requester request accept; at most one bit high.
- `req_a0`, `req_b0` input [3:0]: requester 0 operands.
- `req_a1`, `req_b1` input [3:0]: requester 1 operands.
- `req_op0`, `req_op1` input [2:0]: requester op codes.
- `resp_valid` output [1:0]: per-requester response valid; at most one bit high.
- `resp_ready` input [1:0]: per-requester response accept.
- `resp_result` output [3:0]: registered ALU result, shared bus.
- `resp_carry` output 1: registered ALU carry_out, shared bus.
- `busy` output 1: high in every state except IDLE.
- `ops_done` output [7:0]: completed-transaction counter; wraps 255 -> 0.

## Operation
- Op codes are passed through unchanged:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor.
  - 101 not a, 110 a<<1, 111 a>>1.
  - b is ignored for codes 101-111.
- FSM states:
  - IDLE: arbitrate. If any `req_valid` is set, raise `req_ready` for the grantee. On the handshake, latch a, b, op and the grantee id, then go to EXEC.
  - EXEC: the ALU evaluates the latched registers. Capture result and carry into the response registers, then go to RESP.
  - RESP: hold `resp_valid[id]` and the shared bus stable until `resp_ready[id]`. On that handshake, increment `ops_done`, update `last_grant` to id, and go to IDLE.
- Round-robin arbitration:
  - With one requester valid, it wins.
  - With both valid, the requester other than `last_grant` wins.
  - `last_grant` resets to 1, so requester 0 wins the first contest.
- `req_ready` is combinational from state, `last_grant` and `req_valid`. It never depends on the payload.
- Requesters must hold `req_valid` and the payload stable until accepted. Deasserting `req_valid` before acceptance withdraws the request and is legal.
- `resp_ready` on a non-addressed requester is ignored.

## Timing
- Reset values: `req_ready`=0 (outside IDLE), `resp_valid`=0, `resp_result`=0, `resp_carry`=0, `busy`=0, `ops_done`=0, state=IDLE, `last_grant`=1, operand and id registers=0.
- Latency:
  - Request handshake in cycle N.
  - EXEC in cycle N+1.
  - `resp_valid` high from cycle N+2.
  - With `resp_ready` already high, the earliest next accept is cycle N+3.
  - Peak throughput is 1 op per 3 cycles.
- Response back-pressure: the response holds indefinitely with no timeout. The other requester stalls meanwhile.
- Simultaneous `resp_ready[id]` and a new `req_valid`: the response completes and state returns to IDLE. The new request is accepted no earlier than the next cycle.
- Arithmetic: result is W bits and truncates per the ALU; `resp_carry` is whatever the ALU drives for the op.
- `ops_done` wraps silently 8'hFF -> 8'h00.
- Reset asserted mid-transaction (EXEC or RESP) discards the transaction. Outputs go to reset values immediately, with no response delivered and no count.

## Structure
- The shared package `alu_pkg` holds:
  - the op-code localparams (`OP_ADD` .. `OP_SHR`);
  - the FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2);
  - the width constant W=4.
- One sub-module: the existing combinational `ALU` (a, b, op_code -> result, carry_out), instantiated once and fed only from the latched registers.
- The arbitration logic stays inline; no separate arbiter module.

## Test plan
- Single add: requester 0 sends a=0011, b=0101, op=000 -> `req_ready[0]` in the same cycle, `resp_valid[0]` 2 cycles later, result=1000, carry=0, `ops_done`=1.
- Carry out: requester 1 sends a=1111, b=0001, op=000 -> `resp_valid[1]`, result=0000, carry=1.
- Contention: both valid from reset with ops and (op 010, 1100/1010) and or (op 011, 1100/1010) -> requester 0 served first with 1000, then requester 1 with 1110. A second simultaneous contest goes to requester 0 again only after requester 1 was last.
- Back-pressure: hold `resp_ready`=0 for 5 cycles -> `resp_valid` and result stay stable, `busy`=1, and the other requester's `req_ready` stays 0. Releasing it completes, and the count increments by exactly 1.
- Reset in RESP: assert `rst` while `resp_valid`=1 -> all outputs 0 asynchronously, `ops_done` unchanged from its pre-reset reset value 0, and the next contest goes to requester 0.
- Wrap: run 256 back-to-back shift-left ops (a=0011 -> 0110) -> `ops_done` returns to 0, and every result is 0110.
